// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD scan-out block.
// PPU mode codes, the rgb8_t colour bundle and the constant palettes.
package lcd_pkg;

   localparam logic [1:0] MODE_HBLANK = 2'b00;
   localparam logic [1:0] MODE_VBLANK = 2'b01;
   localparam logic [1:0] MODE_OAM    = 2'b10;
   localparam logic [1:0] MODE_VRAM   = 2'b11;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8_t;

   // Entry 0 is the lightest shade, entry 3 the darkest.
   localparam rgb8_t [3:0] PAL_GRAY = {
      24'h000000,
      24'h555555,
      24'hAAAAAA,
      24'hFFFFFF
   };

   localparam rgb8_t [3:0] PAL_GREEN = {
      24'h0F380F,
      24'h306230,
      24'h8BAC0F,
      24'h9BBC0F
   };

   function automatic rgb8_t pal_lookup(
      input logic [1:0] code,
      input logic       tint
   );
      return tint ? PAL_GREEN[code]
                  : PAL_GRAY[code];
   endfunction

endpackage

// File: rtl/lcd_line_ram.sv
// lcd_line_ram: simple dual-port line store, one write and one
// registered read port (clk; we/waddr/wdata in; raddr in, rdata out).
module lcd_line_ram #(
   parameter int DW    = 2,
   parameter int DEPTH = 320,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/lcd_scan.sv
// lcd_scan: captures the PPU pixel stream into an NBUF-line ring and
// replays it as a VGA-style raster with REP-fold vertical replication.
// Ports: clk, reset_n (async low); clkena/data/mode from the PPU;
// tint, pclk, on controls; hs, vs, r, g, b, active registered outputs.
// Build option: LCD_PALETTE_EN selects the constant gray/green palette.
module lcd_scan
   import lcd_pkg::*;
#(
   parameter int PW   = 2,
   parameter int H    = 160,
   parameter int HFP  = 24,
   parameter int HS   = 20,
   parameter int HBP  = 24,
   parameter int V_IN = 144,
   parameter int REP  = 4,
   parameter int VFP  = 2,
   parameter int VS   = 2,
   parameter int VBP  = 36,
   parameter int NBUF = 2,
   parameter int VOFS = 4,
   parameter int CW   = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clkena,
   input  logic [PW-1:0] data,
   input  logic [1:0]    mode,
   input  logic          tint,
   input  logic          pclk,
   input  logic          on,
   output logic          hs,
   output logic          vs,
   output logic [CW-1:0] r,
   output logic [CW-1:0] g,
   output logic [CW-1:0] b,
   output logic          active
);

   localparam int HT    = H + HFP + HS + HBP;
   localparam int V     = V_IN * REP;
   localparam int VT    = V + VFP + VS + VBP;
   localparam int DEPTH = NBUF * H;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = $clog2(NBUF);
   localparam int PTW   = $clog2(H + 1);
   localparam int HW    = $clog2(HT);
   localparam int VW    = $clog2(VT);
   localparam int RW    = (REP > 1) ? $clog2(REP) : 1;

   logic [1:0]     mode_r;
   logic [1:0]     smode;
   logic [1:0]     lmode;
   logic           pclk_r;
   logic           pclk_rr;
   logic           strobe;
   logic [BW-1:0]  wbuf;
   logic [BW-1:0]  rbuf;
   logic [PTW-1:0] wptr;
   logic [PTW-1:0] rptr;
   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic [VW-1:0]  v_nxt;
   logic [RW-1:0]  rep_cnt;
   logic [PW-1:0]  q;
   logic [PW-1:0]  pix;
   logic [1:0]     code;
   rgb8_t          col;
   logic           line_edge;
   logic           we;
   logic           h_wrap;
   logic           h_sync;
   logic           v_exit;
   logic           rep_wrap;
   logic           visible;

   function automatic logic [AW-1:0] addr_of(
      input logic [BW-1:0]  bsel,
      input logic [PTW-1:0] ptr
   );
      return AW'(int'(bsel) * H + int'(ptr));
   endfunction

   // Stretch or trim an 8-bit level to CW bits, MSB first.
   function automatic logic [CW-1:0] fit(
      input logic [7:0] v
   );
      logic [CW-1:0] f;
      for (int i = 0; i < CW; i++)
         f[CW-1-i] = v[7 - (i % 8)];
      return f;
   endfunction

   // Line start is the first clk where the raw mode leaves hblank.
   assign line_edge = (mode_r == MODE_HBLANK) &&
                      (mode != MODE_HBLANK);
   assign we = clkena && !line_edge &&
               (wptr != PTW'(H));
   assign strobe = pclk_r && !pclk_rr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_r  <= MODE_HBLANK;
         pclk_r  <= 1'b0;
         pclk_rr <= 1'b0;
         wbuf    <= '0;
         wptr    <= '0;
      end else begin
         mode_r  <= mode;
         pclk_r  <= pclk;
         pclk_rr <= pclk_r;
         if (line_edge) begin
            wptr <= '0;
            wbuf <= wbuf + BW'(1);
         end else if (we) begin
            wptr <= wptr + PTW'(1);
         end
      end
   end

   lcd_line_ram #(
      .DW    (PW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (addr_of(wbuf, wptr)),
      .wdata (data),
      .raddr (addr_of(rbuf, rptr)),
      .rdata (q)
   );

   always_comb begin
      h_wrap   = (h_cnt == HW'(HT - 1));
      h_sync   = (mode_r == MODE_OAM) &&
                 (smode == MODE_HBLANK);
      v_exit   = (lmode == MODE_VBLANK) &&
                 (mode_r != MODE_VBLANK);
      rep_wrap = (rep_cnt == RW'(REP - 1));
      visible  = (v_cnt < VW'(V)) &&
                 (h_cnt < HW'(H));
      pix      = visible ? q : '0;
      if (v_exit)
         v_nxt = VW'(VT - VOFS);
      else if (v_cnt == VW'(VT - 1))
         v_nxt = '0;
      else
         v_nxt = v_cnt + VW'(1);
   end

   always_comb begin
      code = on ? pix[PW-1 -: 2] : 2'b00;
`ifdef LCD_PALETTE_EN
      col = pal_lookup(code, tint);
`else
      col = '{r: {4{~code}},
              g: {4{~code}},
              b: {4{~code}}};
`endif
   end

`ifndef LCD_PALETTE_EN
   logic unused_tint;
   assign unused_tint = tint;
`endif

   logic unused_pix;
   assign unused_pix = ^pix;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         smode   <= MODE_HBLANK;
         lmode   <= MODE_HBLANK;
         h_cnt   <= '0;
         v_cnt   <= '0;
         rep_cnt <= '0;
         rbuf    <= BW'(NBUF - 1);
         rptr    <= '0;
         hs      <= 1'b1;
         vs      <= 1'b0;
         r       <= '0;
         g       <= '0;
         b       <= '0;
         active  <= 1'b0;
      end else if (strobe) begin
         smode <= mode_r;
         if (h_sync || h_wrap)
            h_cnt <= '0;
         else
            h_cnt <= h_cnt + HW'(1);

         if (h_cnt == HW'(H + HFP))
            hs <= 1'b0;
         else if (h_cnt == HW'(H + HFP + HS))
            hs <= 1'b1;

         if (h_wrap) begin
            lmode <= mode_r;
            v_cnt <= v_nxt;
            // vs follows the line being entered.
            if (v_nxt == VW'(V + VFP))
               vs <= 1'b1;
            else if (v_nxt == VW'(V + VFP + VS))
               vs <= 1'b0;
            if (v_exit) begin
               rep_cnt <= '0;
               rbuf    <= wbuf - BW'(1);
            end else if (rep_wrap) begin
               rep_cnt <= '0;
               rbuf    <= wbuf - BW'(1);
            end else begin
               rep_cnt <= rep_cnt + RW'(1);
            end
         end

         // RAM output is already valid for rptr; it advances per pixel.
         if (visible && !h_sync)
            rptr <= rptr + PTW'(1);
         else
            rptr <= '0;

         r      <= fit(col.r);
         g      <= fit(col.g);
         b      <= fit(col.b);
         active <= visible;
      end
   end

endmodule

// File: tb/tb_lcd_scan.sv
// tb_lcd_scan: directed bench for lcd_scan on a reduced raster
// (H=8, HT=16, V=8, VT=16, REP=2, VOFS=3).
module tb_lcd_scan;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clkena = 1'b0;
   logic [1:0] data = 2'd0;
   logic [1:0] mode = 2'b00;
   logic       tint = 1'b0;
   logic       pclk = 1'b0;
   logic       on = 1'b1;
   logic       hs;
   logic       vs;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;
   logic       active;

   int errors = 0;
   int checks = 0;
   logic [1:0] pat [2][8];

   always #5 clk = ~clk;

   lcd_scan #(
      .PW(2), .H(8), .HFP(3), .HS(2), .HBP(3),
      .V_IN(4), .REP(2), .VFP(2), .VS(2), .VBP(4),
      .NBUF(2), .VOFS(3), .CW(8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clkena  (clkena),
      .data    (data),
      .mode    (mode),
      .tint    (tint),
      .pclk    (pclk),
      .on      (on),
      .hs      (hs),
      .vs      (vs),
      .r       (r),
      .g       (g),
      .b       (b),
      .active  (active)
   );

   initial begin
      #1000000;
      $display("FAIL timeout: sim did not end, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rgb(
      input logic [1:0] c,
      input logic       t,
      input logic       o
   );
      logic [1:0] k;
      k = o ? c : 2'd0;
`ifdef LCD_PALETTE_EN
      if (t) begin
         case (k)
            2'd0:    return 32'h009BBC0F;
            2'd1:    return 32'h008BAC0F;
            2'd2:    return 32'h00306230;
            default: return 32'h000F380F;
         endcase
      end
`endif
      case (k)
         2'd0:    return 32'h00FFFFFF;
         2'd1:    return 32'h00AAAAAA;
         2'd2:    return 32'h00555555;
         default: return 32'h00000000;
      endcase
   endfunction

   task automatic strobe();
      pclk = 1'b1;
      @(posedge clk); #1;
      pclk = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [1:0] d);
      clkena = 1'b1;
      data = d;
      @(posedge clk); #1;
      clkena = 1'b0;
   endtask

   task automatic do_line(
      input int v,
      input int ps,
      input bit sync_end
   );
      bit vis;
      for (int h = 0; h < 16; h++) begin
         if (sync_end && h == 15) begin
            mode = 2'b10;
            @(posedge clk); #1;
         end
         strobe();
         vis = (v < 8) && (h < 8);
         check($sformatf("act v%0d h%0d", v, h),
               {31'd0, active}, {31'd0, vis});
         check($sformatf("hs v%0d h%0d", v, h),
               {31'd0, hs},
               {31'd0, !(h == 11 || h == 12)});
         if (vis)
            check($sformatf("rgb v%0d h%0d", v, h),
                  {8'd0, r, g, b},
                  exp_rgb(pat[ps][h], tint, on));
         if (h == 0)
            check($sformatf("vs v%0d", v),
                  {31'd0, vs},
                  {31'd0, (v == 10 || v == 11)});
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         pat[0][i] = 2'(i % 4);
         pat[1][i] = 2'(3 - (i % 4));
      end

      repeat (5) @(posedge clk); #1;
      check("rst hs", {31'd0, hs}, 32'd1);
      check("rst vs", {31'd0, vs}, 32'd0);
      check("rst rgb", {8'd0, r, g, b}, 32'd0);
      check("rst act", {31'd0, active}, 32'd0);

      reset_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      check("idle hs", {31'd0, hs}, 32'd1);
      check("idle rgb", {8'd0, r, g, b}, 32'd0);
      check("idle act", {31'd0, active}, 32'd0);

      // Line 1 into buffer 1, with 4 overflow writes.
      mode = 2'b10;
      @(posedge clk); #1;
      mode = 2'b11;
      for (int i = 0; i < 12; i++)
         wr(i < 8 ? pat[0][i] : 2'd3);
      mode = 2'b00;
      @(posedge clk); #1;
      // Line 2 into buffer 0; the pixel on the edge is dropped.
      mode = 2'b10;
      wr(2'd2);
      for (int i = 0; i < 8; i++)
         wr(pat[1][i]);
      mode = 2'b00;
      @(posedge clk); #1;

      do_line(0, 0, 1'b0);
      do_line(1, 0, 1'b1);
      tint = 1'b1;
      do_line(2, 1, 1'b0);
      on = 1'b0;
      mode = 2'b01;
      do_line(3, 1, 1'b0);
      tint = 1'b0;
      on = 1'b1;
      mode = 2'b00;
      do_line(4, 1, 1'b0);
      for (int v = 13; v < 16; v++)
         do_line(v, 1, 1'b0);
      for (int v = 0; v < 10; v++)
         do_line(v, 1, 1'b0);

      for (int h = 0; h < 12; h++)
         strobe();
      check("pre-rst hs", {31'd0, hs}, 32'd0);
      check("pre-rst vs", {31'd0, vs}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid-rst hs", {31'd0, hs}, 32'd1);
      check("mid-rst vs", {31'd0, vs}, 32'd0);
      check("mid-rst act", {31'd0, active}, 32'd0);
      check("mid-rst rgb", {8'd0, r, g, b}, 32'd0);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
